csi_framer: RTL and testbench
=============================

Name: csi_framer

Overview:
- Sits directly downstream of the CSI extractor and consumes its csi_axis stream: one CSI frame is FRAME_LEN words of {re[15:0], im[15:0]}, with tlast on the final word.
- Validates frame length and buffers frames in a two-bank ping-pong RAM. Each frame gets a 2-word header (magic+sequence, timestamp) and is emitted as one AXI-Stream packet toward the DMA.
- Never backpressures the extractor; when no bank is free, the whole frame is dropped and counted.

Parameters:
- FRAME_LEN, 64, payload words per CSI frame (power of two, 16..256).
- MAGIC, 16'hC510, upper half of header word 0.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- csi_axis_tvalid  input  1  CSI word valid
- csi_axis_tlast  input  1  last CSI word of frame
- csi_axis_tdata  input  32  {re, im}
- csi_axis_tready  output  1  tied 1 when out of reset
- dma_axis_tvalid  output  1  output word valid
- dma_axis_tlast  output  1  last word of packet
- dma_axis_tdata  output  32  header or payload word
- dma_axis_tready  input  1  downstream ready
- frames_sent_out  output  32  packets fully emitted (wraps)
- drop_count_out  output  16  frames dropped for lack of a bank (saturates at FFFF)
- err_count_out  output  16  malformed frames discarded (saturates)

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is asynchronous and active-high.
- Reset values: all outputs 0, except csi_axis_tready, which is 0 only while rst_in is high. All banks FREE, wr_ptr=rd_ptr=0, seq=0, timestamp counter=0.
- Reset mid-operation: in-flight frames are discarded. dma_axis_tvalid drops in the same instant, with no partial-packet completion.
- Timestamp counter: free-running 32-bit cycle counter, wraps.
- Word accepted: a CSI word is accepted on every cycle with csi_axis_tvalid=1.
- Bank states: FREE, FILLING, FULL, READING.
- Input FSM states: IDLE, WRITE, DISCARD.
- IDLE, first word arrives:
  - seq increments and the pre-increment value is used for this frame; seq increments on every frame start, including dropped and bad frames, so the host sees gaps.
  - If bank[wr_ptr] is FREE: mark it FILLING, latch seq and timestamp into that bank's metadata, write word 0, go to WRITE.
  - Otherwise: drop_count++ and go to DISCARD.
  - If this first word also carries tlast, treat it as a short frame: err_count++, bank (if taken) back to FREE, stay IDLE.
- WRITE:
  - Write word at index wcnt.
  - tlast with wcnt==FRAME_LEN-1: bank becomes FULL, wr_ptr toggles, go to IDLE.
  - tlast earlier (short frame): err_count++, bank back to FREE, wr_ptr unchanged, go to IDLE.
  - wcnt==FRAME_LEN-1 without tlast (long frame): err_count++, bank back to FREE, go to DISCARD.
- DISCARD: ignore words until the tlast word is accepted, then go to IDLE. No further counter increments.
- Bank release: a bank released by the output side in cycle N is visible to allocation from cycle N+1.
- Output FSM states: IDLE, HDR0, HDR1, PAYLOAD.
  - IDLE: when bank[rd_ptr] is FULL, mark it READING and go to HDR0.
  - HDR0 emits {MAGIC, seq}. HDR1 emits timestamp.
  - PAYLOAD emits words 0..FRAME_LEN-1; tlast is asserted on the final word only. Packet length is FRAME_LEN+2.
  - On the final handshake: bank becomes FREE, rd_ptr toggles, frames_sent_out++, go to IDLE.
  - Latency from the input tlast word being accepted to HDR0 tvalid is at most 2 cycles when the output FSM is idle.
- AXIS output rules:
  - tdata and tlast are stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - The 1-cycle RAM read latency is hidden by a prefetch register, so there are no bubbles when tready is held high. The payload sustains 1 word/cycle.
- Ordering: frames are emitted in arrival order.
- Banks: reading one bank while filling the other is allowed.
- Saturating counters hold at FFFF.

Decomposition:
- csi_pkg contains: CSI_MAGIC, default CSI_FRAME_LEN, the bank-state enum (FREE, FILLING, FULL, READING), and the input and output FSM enums.
- One sub-module, csi_bank_ram: simple dual-port RAM, 2*FRAME_LEN x 32.
  - Address is {bank, index}.
  - 1 write port; 1 read port with 1-cycle registered read.
  - Infers BRAM/LUTRAM.

Test Plan:
- Single frame: 64 words with tdata=i, tlast on i=63, dma_tready=1 → 66-word packet.
  - Word 0 = C5100000, word 1 = cycle at word-0 acceptance, words 2..65 = 0..63, tlast only on word 65.
  - frames_sent_out=1.
- Backpressure: same frame, dma_tready toggling 1/0 every cycle and then random.
  - Payload identical and in order; tdata held stable whenever tvalid=1 and tready=0.
- Overflow: dma_tready=0 while 3 back-to-back frames arrive, then tready=1.
  - Two packets with seq 0 and 1; drop_count=1.
  - Next frame after the drain carries seq=3.
- Short frame: tlast at word 10, then a good frame.
  - err_count=1; only one packet emitted, with seq=1; bank reused.
- Long frame: 80 words with tlast at word 79, then a good frame.
  - err_count=1, words 64..79 ignored, next frame emitted correctly.
- Reset mid-packet: assert rst_in during PAYLOAD word 20.
  - tvalid=0 immediately; all counters 0.
  - The post-reset frame is emitted as seq 0.

Source files
------------

// File: rtl/csi_pkg.sv
// Shared constants, state encodings and helpers for the CSI framer.
package csi_pkg;

  localparam logic [15:0] CSI_MAGIC     = 16'hC510;
  localparam int unsigned CSI_FRAME_LEN = 64;

  // Per-bank ownership state of the ping-pong buffer.
  typedef enum logic [1:0] {
    BankFree,
    BankFilling,
    BankFull,
    BankReading
  } bank_state_e;

  typedef enum logic [1:0] {
    InIdle,
    InWrite,
    InDiscard
  } in_state_e;

  typedef enum logic [1:0] {
    OutIdle,
    OutHdr0,
    OutHdr1,
    OutPayload
  } out_state_e;

  // Saturating 16-bit increment used by the error/drop counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/csi_bank_ram.sv
// Simple dual-port frame buffer: two banks of FrameLen words, address {bank, index}.
// One write port, one read port with a registered read (1-cycle latency).
module csi_bank_ram #(
  parameter int unsigned FrameLen = 64,
  parameter int unsigned AddrW    = $clog2(FrameLen) + 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  localparam int unsigned Depth = 2 * FrameLen;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; the output holds while re_i is low so it doubles as a prefetch stage.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/csi_framer.sv
// CSI framer: validates incoming CSI frames, buffers them in a two-bank ping-pong RAM and
// emits each good frame as an AXI-Stream packet {MAGIC,seq}, timestamp, payload[0..N-1].
// The input side never backpressures; frames with no free bank are dropped and counted.
module csi_framer
  import csi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = CSI_FRAME_LEN,
  parameter logic [15:0] MAGIC     = CSI_MAGIC
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        csi_axis_tvalid,
  input  logic        csi_axis_tlast,
  input  logic [31:0] csi_axis_tdata,
  output logic        csi_axis_tready,
  output logic        dma_axis_tvalid,
  output logic        dma_axis_tlast,
  output logic [31:0] dma_axis_tdata,
  input  logic        dma_axis_tready,
  output logic [31:0] frames_sent_out,
  output logic [15:0] drop_count_out,
  output logic [15:0] err_count_out
);

  localparam int unsigned     IdxW    = $clog2(FRAME_LEN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

  // Shared bank bookkeeping.
  bank_state_e     bank_st_q  [2];
  bank_state_e     bank_st_d  [2];
  logic [15:0]     meta_seq_q [2];
  logic [15:0]     meta_seq_d [2];
  logic [31:0]     meta_ts_q  [2];
  logic [31:0]     meta_ts_d  [2];

  // Input side.
  in_state_e       in_state_q, in_state_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [IdxW-1:0] wcnt_q, wcnt_d;
  logic [15:0]     seq_q, seq_d;
  logic [31:0]     ts_q, ts_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            in_alloc, in_commit, in_abort;
  logic            ram_we;
  logic [IdxW-1:0] ram_widx;

  // Output side.
  out_state_e      out_state_q, out_state_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [IdxW-1:0] pcnt_q, pcnt_d;
  logic [IdxW-1:0] rcnt_q, rcnt_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [31:0]     frames_q, frames_d;
  logic            out_take, out_release;
  logic            ram_re;
  logic [IdxW-1:0] ram_ridx;
  logic [31:0]     ram_rdata;
  logic            handshake;

  assign csi_axis_tready = ~rst_in;
  assign handshake       = out_valid_q & dma_axis_tready;

  csi_bank_ram #(
    .FrameLen (FRAME_LEN),
    .AddrW    (IdxW + 1)
  ) u_ram (
    .clk_i   (clk_in),
    .we_i    (ram_we),
    .waddr_i ({wr_ptr_q, ram_widx}),
    .wdata_i (csi_axis_tdata),
    .re_i    (ram_re),
    .raddr_i ({rd_ptr_q, ram_ridx}),
    .rdata_o (ram_rdata)
  );

  // Input FSM: frame start/allocation, length validation and drop/error accounting.
  always_comb begin
    in_state_d = in_state_q;
    wr_ptr_d   = wr_ptr_q;
    wcnt_d     = wcnt_q;
    seq_d      = seq_q;
    ts_d       = ts_q + 32'd1;
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    in_alloc   = 1'b0;
    in_commit  = 1'b0;
    in_abort   = 1'b0;
    ram_we     = 1'b0;
    ram_widx   = wcnt_q;
    if (csi_axis_tvalid) begin
      case (in_state_q)
        InIdle: begin
          // Every frame start consumes a sequence number so the host can see gaps.
          seq_d = seq_q + 16'd1;
          if (bank_st_q[wr_ptr_q] == BankFree) begin
            if (csi_axis_tlast) begin
              err_cnt_d = sat_inc16(err_cnt_q);
            end else begin
              in_alloc   = 1'b1;
              ram_we     = 1'b1;
              ram_widx   = '0;
              wcnt_d     = IdxW'(1);
              in_state_d = InWrite;
            end
          end else begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
            if (!csi_axis_tlast) begin
              in_state_d = InDiscard;
            end
          end
        end
        InWrite: begin
          ram_we = 1'b1;
          wcnt_d = wcnt_q + IdxW'(1);
          if (csi_axis_tlast) begin
            in_state_d = InIdle;
            if (wcnt_q == LastIdx) begin
              in_commit = 1'b1;
              wr_ptr_d  = ~wr_ptr_q;
            end else begin
              in_abort  = 1'b1;
              err_cnt_d = sat_inc16(err_cnt_q);
            end
          end else if (wcnt_q == LastIdx) begin
            // Over-long frame: release the bank and swallow the tail.
            in_abort   = 1'b1;
            err_cnt_d  = sat_inc16(err_cnt_q);
            in_state_d = InDiscard;
          end
        end
        InDiscard: begin
          if (csi_axis_tlast) begin
            in_state_d = InIdle;
          end
        end
        default: in_state_d = InIdle;
      endcase
    end
  end

  // Output FSM: header generation and payload streaming through the RAM prefetch stage.
  // The RAM output register always holds the next payload word; a read is issued only
  // when that word is moved into the output register, so backpressure never loses data.
  always_comb begin
    out_state_d = out_state_q;
    rd_ptr_d    = rd_ptr_q;
    pcnt_d      = pcnt_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    frames_d    = frames_q;
    out_take    = 1'b0;
    out_release = 1'b0;
    ram_re      = 1'b0;
    ram_ridx    = rcnt_q;
    case (out_state_q)
      OutIdle: begin
        if (bank_st_q[rd_ptr_q] == BankFull) begin
          out_take    = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_data_d  = {MAGIC, meta_seq_q[rd_ptr_q]};
          ram_re      = 1'b1;
          ram_ridx    = '0;
          rcnt_d      = IdxW'(1);
          out_state_d = OutHdr0;
        end
      end
      OutHdr0: begin
        if (handshake) begin
          out_data_d  = meta_ts_q[rd_ptr_q];
          out_state_d = OutHdr1;
        end
      end
      OutHdr1: begin
        if (handshake) begin
          out_data_d  = ram_rdata;
          out_last_d  = 1'b0;
          pcnt_d      = '0;
          ram_re      = 1'b1;
          rcnt_d      = rcnt_q + IdxW'(1);
          out_state_d = OutPayload;
        end
      end
      OutPayload: begin
        if (handshake) begin
          if (pcnt_q == LastIdx) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_release = 1'b1;
            rd_ptr_d    = ~rd_ptr_q;
            frames_d    = frames_q + 32'd1;
            out_state_d = OutIdle;
          end else begin
            out_data_d = ram_rdata;
            pcnt_d     = pcnt_q + IdxW'(1);
            out_last_d = ((pcnt_q + IdxW'(1)) == LastIdx);
            ram_re     = 1'b1;
            rcnt_d     = rcnt_q + IdxW'(1);
          end
        end
      end
      default: out_state_d = OutIdle;
    endcase
  end

  // Bank ownership: input and output sides only touch banks in disjoint states.
  always_comb begin
    bank_st_d  = bank_st_q;
    meta_seq_d = meta_seq_q;
    meta_ts_d  = meta_ts_q;
    if (in_alloc) begin
      bank_st_d[wr_ptr_q]  = BankFilling;
      meta_seq_d[wr_ptr_q] = seq_q;
      meta_ts_d[wr_ptr_q]  = ts_q;
    end
    if (in_commit) begin
      bank_st_d[wr_ptr_q] = BankFull;
    end
    if (in_abort) begin
      bank_st_d[wr_ptr_q] = BankFree;
    end
    if (out_take) begin
      bank_st_d[rd_ptr_q] = BankReading;
    end
    if (out_release) begin
      bank_st_d[rd_ptr_q] = BankFree;
    end
  end

  // State registers for both FSMs, bank bookkeeping and counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int b = 0; b < 2; b++) begin
        bank_st_q[b]  <= BankFree;
        meta_seq_q[b] <= '0;
        meta_ts_q[b]  <= '0;
      end
      in_state_q  <= InIdle;
      wr_ptr_q    <= 1'b0;
      wcnt_q      <= '0;
      seq_q       <= '0;
      ts_q        <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
      out_state_q <= OutIdle;
      rd_ptr_q    <= 1'b0;
      pcnt_q      <= '0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      frames_q    <= '0;
    end else begin
      bank_st_q   <= bank_st_d;
      meta_seq_q  <= meta_seq_d;
      meta_ts_q   <= meta_ts_d;
      in_state_q  <= in_state_d;
      wr_ptr_q    <= wr_ptr_d;
      wcnt_q      <= wcnt_d;
      seq_q       <= seq_d;
      ts_q        <= ts_d;
      drop_cnt_q  <= drop_cnt_d;
      err_cnt_q   <= err_cnt_d;
      out_state_q <= out_state_d;
      rd_ptr_q    <= rd_ptr_d;
      pcnt_q      <= pcnt_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      frames_q    <= frames_d;
    end
  end

  assign dma_axis_tvalid = out_valid_q;
  assign dma_axis_tlast  = out_last_q;
  assign dma_axis_tdata  = out_data_q;
  assign frames_sent_out = frames_q;
  assign drop_count_out  = drop_cnt_q;
  assign err_count_out   = err_cnt_q;

endmodule

// File: tb/tb_csi_framer.sv
// Scoreboard bench for csi_framer: the stimulus side queues the expected packet words,
// an independent monitor pops and compares them on every output handshake.
module tb_csi_framer;

  localparam int unsigned FL = 64;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        csi_axis_tvalid = 1'b0;
  logic        csi_axis_tlast = 1'b0;
  logic [31:0] csi_axis_tdata = '0;
  logic        csi_axis_tready;
  logic        dma_axis_tvalid;
  logic        dma_axis_tlast;
  logic [31:0] dma_axis_tdata;
  logic        dma_axis_tready = 1'b0;
  logic [31:0] frames_sent_out;
  logic [15:0] drop_count_out;
  logic [15:0] err_count_out;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  int          pkt_idx = 0;
  logic [31:0] cyc;
  int          rdy_mode = 0;     // 0: hold rdy_hold, 1: toggle, 2: random
  logic        rdy_hold = 1'b1;

  always #5 clk_in = ~clk_in;

  csi_framer #(
    .FRAME_LEN (FL),
    .MAGIC     (16'hC510)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .csi_axis_tvalid (csi_axis_tvalid),
    .csi_axis_tlast  (csi_axis_tlast),
    .csi_axis_tdata  (csi_axis_tdata),
    .csi_axis_tready (csi_axis_tready),
    .dma_axis_tvalid (dma_axis_tvalid),
    .dma_axis_tlast  (dma_axis_tlast),
    .dma_axis_tdata  (dma_axis_tdata),
    .dma_axis_tready (dma_axis_tready),
    .frames_sent_out (frames_sent_out),
    .drop_count_out  (drop_count_out),
    .err_count_out   (err_count_out)
  );

  // Reference cycle count: value seen during a cycle equals the DUT timestamp then.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      case (rdy_mode)
        0:       dma_axis_tready = rdy_hold;
        1:       dma_axis_tready = ~dma_axis_tready;
        default: dma_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks AXIS hold rules and scoreboards every accepted word.
  initial begin
    logic        prev_stall;
    logic [32:0] prev_word;
    logic [32:0] e;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        prev_stall = 1'b0;
        pkt_idx    = 0;
      end else begin
        if (prev_stall) begin
          check32("hold_valid", {31'd0, dma_axis_tvalid}, 32'd1);
          check32("hold_data", dma_axis_tdata, prev_word[31:0]);
          check32("hold_last", {31'd0, dma_axis_tlast}, {31'd0, prev_word[32]});
        end
        if (dma_axis_tvalid && dma_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %08h expected no word", dma_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            check32("dma_data", dma_axis_tdata, e[31:0]);
            check32("dma_last", {31'd0, dma_axis_tlast}, {31'd0, e[32]});
          end
          pkt_idx = dma_axis_tlast ? 0 : pkt_idx + 1;
        end
        prev_stall = dma_axis_tvalid && !dma_axis_tready;
        prev_word  = {dma_axis_tlast, dma_axis_tdata};
      end
    end
  end

  task automatic check_counters(input string tag, input logic [31:0] frames,
                                input logic [15:0] drops, input logic [15:0] errs);
    check32({tag, "_frames"}, frames_sent_out, frames);
    check32({tag, "_drops"}, {16'd0, drop_count_out}, {16'd0, drops});
    check32({tag, "_errs"}, {16'd0, err_count_out}, {16'd0, errs});
  endtask

  // Asserts reset at the current time, checks reset values, releases at posedge+1.
  task automatic do_reset();
    rst_in          = 1'b1;
    csi_axis_tvalid = 1'b0;
    csi_axis_tlast  = 1'b0;
    csi_axis_tdata  = '0;
    exp_q.delete();
    #1;
    check32("rst_tvalid", {31'd0, dma_axis_tvalid}, 32'd0);
    check32("rst_tready", {31'd0, csi_axis_tready}, 32'd0);
    check_counters("rst", 32'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    #1;
    check32("run_tready", {31'd0, csi_axis_tready}, 32'd1);
    @(posedge clk_in);
    #1;
  endtask

  // Drives nwords back-to-back words (tlast on index last_at); queues the packet if emit.
  task automatic send_frame(input int nwords, input int last_at, input bit emit,
                            input logic [15:0] seq, input logic [31:0] base);
    for (int i = 0; i < nwords; i++) begin
      csi_axis_tvalid = 1'b1;
      csi_axis_tlast  = (i == last_at);
      csi_axis_tdata  = base + 32'(i);
      if (i == 0 && emit) begin
        exp_q.push_back({1'b0, 16'hC510, seq});
        exp_q.push_back({1'b0, cyc});
        for (int j = 0; j < int'(FL); j++) begin
          exp_q.push_back({(j == int'(FL) - 1), base + 32'(j)});
        end
      end
      @(posedge clk_in);
      #1;
    end
    csi_axis_tvalid = 1'b0;
    csi_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (exp_q.size() == 0 && !dma_axis_tvalid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk_in);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d words pending expected 0", tag, exp_q.size());
    end
    repeat (4) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;

    // Single frame, tready held high.
    do_reset();
    send_frame(FL, FL - 1, 1'b1, 16'd0, 32'd0);
    wait_drain("single");
    check_counters("single", 32'd1, 16'd0, 16'd0);

    // Backpressure: toggling ready, then random ready.
    do_reset();
    rdy_mode = 1;
    send_frame(FL, FL - 1, 1'b1, 16'd0, 32'h1234_0000);
    wait_drain("toggle");
    rdy_mode = 2;
    send_frame(FL, FL - 1, 1'b1, 16'd1, 32'hABCD_0100);
    wait_drain("random");
    rdy_mode = 0;
    check_counters("bp", 32'd2, 16'd0, 16'd0);

    // Overflow: three back-to-back frames with ready low; the third finds no bank.
    do_reset();
    rdy_hold = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    send_frame(FL, FL - 1, 1'b1, 16'd0, 32'h0000_A000);
    send_frame(FL, FL - 1, 1'b1, 16'd1, 32'h0000_B000);
    send_frame(FL, FL - 1, 1'b0, 16'd2, 32'h0000_C000);
    check_counters("ovf_held", 32'd0, 16'd1, 16'd0);
    rdy_hold = 1'b1;
    wait_drain("ovf");
    check_counters("ovf", 32'd2, 16'd1, 16'd0);
    send_frame(FL, FL - 1, 1'b1, 16'd3, 32'h0000_D000);
    wait_drain("ovf_next");
    check_counters("ovf_next", 32'd3, 16'd1, 16'd0);

    // Short frame then a good one.
    do_reset();
    send_frame(11, 10, 1'b0, 16'd0, 32'h5000_0000);
    send_frame(FL, FL - 1, 1'b1, 16'd1, 32'h5100_0000);
    wait_drain("short");
    check_counters("short", 32'd1, 16'd0, 16'd1);

    // Long frame (80 words) then a good one.
    do_reset();
    send_frame(80, 79, 1'b0, 16'd0, 32'h6000_0000);
    send_frame(FL, FL - 1, 1'b1, 16'd1, 32'h6100_0000);
    wait_drain("long");
    check_counters("long", 32'd1, 16'd0, 16'd1);

    // Reset while payload word 20 (packet word 22) is on the bus.
    send_frame(FL, FL - 1, 1'b1, 16'd2, 32'h7000_0000);
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (dma_axis_tvalid && pkt_idx == 22) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk_in);
      #1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL midrst_reach: got word %0d expected word 22", pkt_idx);
    end
    do_reset();
    send_frame(FL, FL - 1, 1'b1, 16'd0, 32'h8000_0000);
    wait_drain("post_rst");
    check_counters("post_rst", 32'd1, 16'd0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
